// File: rtl/traffic_phase_ctrl_if.sv
// Lamp/timing bundle between the traffic sequencer and its surroundings.
// The master drives the tick strobe and the requests; the slave returns phase, lamps and countdown.
interface traffic_phase_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             tick;
  logic             ped_req;
  logic             night;
  logic [2:0]       phase;
  logic [2:0]       ns_light;
  logic [2:0]       ew_light;
  logic             walk;
  logic             blink;
  logic [CNT_W-1:0] countdown;

  modport master (
    output tick, ped_req, night,
    input  phase, ns_light, ew_light, walk, blink, countdown
  );

  modport slave (
    input  tick, ped_req, night,
    output phase, ns_light, ew_light, walk, blink, countdown
  );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// Two-road traffic-light sequencer stepped by a one-clock tick strobe, with green-end blink,
// pedestrian green shortening on the NS road and a night flashing mode.
module traffic_phase_ctrl #(
  parameter int CNT_W    = 8,
  parameter int GREEN_T  = 10,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 2,
  parameter int BLINK_T  = 3,
  parameter int SHORT_T  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  traffic_phase_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    NS_G    = 3'd0,
    NS_Y    = 3'd1,
    AR1     = 3'd2,
    EW_G    = 3'd3,
    EW_Y    = 3'd4,
    AR2     = 3'd5,
    NIGHT   = 3'd6,
    ILLEGAL = 3'd7
  } phase_t;

  localparam logic [CNT_W-1:0] G_LD      = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] Y_LD      = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_LD     = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] BLINK_MAX = CNT_W'(BLINK_T);
  localparam logic [CNT_W-1:0] SHORT_LD  = CNT_W'(SHORT_T);

  phase_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             blink_q, blink_n;
  logic             ped_pend, ped_n;
  logic             in_green;
  logic [2:0]       ns, ew;

  assign in_green = (state == NS_G) || (state == EW_G);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= AR2;
      cnt      <= AR_LD;
      blink_q  <= 1'b0;
      ped_pend <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      blink_q  <= blink_n;
      ped_pend <= ped_n;
    end
  end

  // Night beats everything on a tick; pedestrian shortening beats the normal decrement.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    blink_n = blink_q;
    ped_n   = ped_pend | bus.ped_req;
    if (state == ILLEGAL) begin
      state_n = AR2;
      cnt_n   = AR_LD;
      blink_n = 1'b0;
    end else if (bus.tick) begin
      if (bus.night) begin
        state_n = NIGHT;
        cnt_n   = '0;
        blink_n = ~blink_q;
      end else if (state == NIGHT) begin
        state_n = AR2;
        cnt_n   = AR_LD;
        blink_n = 1'b0;
      end else begin
        blink_n = (in_green && (cnt != '0) && (cnt <= BLINK_MAX)) ? ~blink_q : 1'b0;
        if ((state == NS_G) && ped_pend && (cnt > SHORT_LD)) begin
          cnt_n = SHORT_LD;
        end else if (cnt != '0) begin
          cnt_n = cnt - CNT_W'(1);
        end else begin
          case (state)
            NS_G: begin state_n = NS_Y; cnt_n = Y_LD;  end
            NS_Y: begin state_n = AR1;  cnt_n = AR_LD; end
            // A request arriving on this very edge is considered served by this walk phase.
            AR1:  begin state_n = EW_G; cnt_n = G_LD;  ped_n = 1'b0; end
            EW_G: begin state_n = EW_Y; cnt_n = Y_LD;  end
            EW_Y: begin state_n = AR2;  cnt_n = AR_LD; end
            default: begin state_n = NS_G; cnt_n = G_LD; end
          endcase
        end
      end
    end
  end

  always_comb begin
    ns = 3'b100;
    ew = 3'b100;
    case (state)
      NS_G:  ns = {2'b00, ~blink_q};
      NS_Y:  ns = 3'b010;
      EW_G:  ew = {2'b00, ~blink_q};
      EW_Y:  ew = 3'b010;
      NIGHT: begin
        ns = {1'b0, blink_q, 1'b0};
        ew = {1'b0, blink_q, 1'b0};
      end
      default: ;
    endcase
  end

  assign bus.phase     = state;
  assign bus.ns_light  = ns;
  assign bus.ew_light  = ew;
  assign bus.walk      = (state == EW_G);
  assign bus.blink     = blink_q;
  assign bus.countdown = cnt;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: a fixed vector table, hand-written corner sequences,
// then random traffic compared against a phase/duration-table reference model.
module tb_traffic_phase_ctrl;

  localparam int CNT_W    = 8;
  localparam int GREEN_T  = 10;
  localparam int YELLOW_T = 3;
  localparam int ALLRED_T = 2;
  localparam int BLINK_T  = 3;
  localparam int SHORT_T  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  traffic_phase_ctrl_if #(.CNT_W(CNT_W)) bus ();

  traffic_phase_ctrl #(
    .CNT_W(CNT_W), .GREEN_T(GREEN_T), .YELLOW_T(YELLOW_T),
    .ALLRED_T(ALLRED_T), .BLINK_T(BLINK_T), .SHORT_T(SHORT_T)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       tick;
    bit       ped;
    bit       night;
    int       ph;
    int       cnt;
    bit       blk;
    bit [2:0] ns;
    bit [2:0] ew;
    bit       walk;
  } vec_t;

  vec_t vecs[22];

  // Reference model: phase index 0..6, ticks left in phase, blink flag, pending request.
  int dur[6] = '{GREEN_T, YELLOW_T, ALLRED_T, GREEN_T, YELLOW_T, ALLRED_T};
  int m_phase, m_cnt;
  bit m_blink, m_ped;

  task automatic model_reset();
    m_phase = 5;
    m_cnt   = ALLRED_T - 1;
    m_blink = 0;
    m_ped   = 0;
  endtask

  task automatic model_edge(bit t, bit p, bit n);
    bit ped_next;
    bit new_blink;
    ped_next = m_ped | p;
    if (t) begin
      if (n) begin
        m_phase = 6;
        m_cnt   = 0;
        m_blink = !m_blink;
      end else if (m_phase == 6) begin
        m_phase = 5;
        m_cnt   = ALLRED_T - 1;
        m_blink = 0;
      end else begin
        new_blink = ((m_phase == 0 || m_phase == 3) && m_cnt >= 1 && m_cnt <= BLINK_T) ? !m_blink : 1'b0;
        if (m_phase == 0 && m_ped && m_cnt > SHORT_T) m_cnt = SHORT_T;
        else if (m_cnt > 0) m_cnt = m_cnt - 1;
        else begin
          m_phase = (m_phase + 1) % 6;
          m_cnt   = dur[m_phase] - 1;
          if (m_phase == 3) ped_next = 0;
        end
        m_blink = new_blink;
      end
    end
    m_ped = ped_next;
  endtask

  function automatic bit [2:0] road_lamp(int green_ph, int yellow_ph);
    if (m_phase == 6) return {1'b0, m_blink, 1'b0};
    if (m_phase == green_ph) return m_blink ? 3'b000 : 3'b001;
    if (m_phase == yellow_ph) return 3'b010;
    return 3'b100;
  endfunction

  task automatic checkOutput(string name, int ph, int cnt, bit blk, bit [2:0] ns, bit [2:0] ew, bit walk);
    tests_run++;
    if (bus.phase !== 3'(ph) || bus.countdown !== CNT_W'(cnt) || bus.blink !== blk ||
        bus.ns_light !== ns || bus.ew_light !== ew || bus.walk !== walk) begin
      tests_failed++;
      $display("[TB] FAIL %s: got phase=%0d cnt=%0d blink=%b ns=%b ew=%b walk=%b, expected phase=%0d cnt=%0d blink=%b ns=%b ew=%b walk=%b",
               name, bus.phase, bus.countdown, bus.blink, bus.ns_light, bus.ew_light, bus.walk,
               ph, cnt, blk, ns, ew, walk);
    end
  endtask

  task automatic check_model(string name);
    checkOutput(name, m_phase, m_cnt, m_blink, road_lamp(0, 1), road_lamp(3, 4), m_phase == 3);
  endtask

  // Inputs change on the falling edge; outputs are compared on the following falling edge.
  task automatic applyStimulus(bit t, bit p, bit n);
    bus.tick    = t;
    bus.ped_req = p;
    bus.night   = n;
    @(posedge clk);
    model_edge(t, p, n);
    @(negedge clk);
  endtask

  task automatic run_until_phase(int target, int max_ticks, string name);
    for (int i = 0; i < max_ticks && bus.phase != 3'(target); i++) begin
      applyStimulus(1, 0, 0);
      check_model(name);
    end
    tests_run++;
    if (bus.phase !== 3'(target)) begin
      tests_failed++;
      $display("[TB] FAIL %s: phase=%0d after %0d ticks, expected phase=%0d", name, bus.phase, max_ticks, target);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not reach its end");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit night_lvl;
    vecs[0]  = '{1, 0, 0, 5, 0, 0, 3'b100, 3'b100, 0};
    vecs[1]  = '{1, 0, 0, 0, 9, 0, 3'b001, 3'b100, 0};
    vecs[2]  = '{0, 0, 0, 0, 9, 0, 3'b001, 3'b100, 0};
    vecs[3]  = '{1, 0, 0, 0, 8, 0, 3'b001, 3'b100, 0};
    vecs[4]  = '{1, 0, 0, 0, 7, 0, 3'b001, 3'b100, 0};
    vecs[5]  = '{1, 0, 0, 0, 6, 0, 3'b001, 3'b100, 0};
    vecs[6]  = '{1, 0, 0, 0, 5, 0, 3'b001, 3'b100, 0};
    vecs[7]  = '{1, 0, 0, 0, 4, 0, 3'b001, 3'b100, 0};
    vecs[8]  = '{1, 0, 0, 0, 3, 0, 3'b001, 3'b100, 0};
    vecs[9]  = '{1, 0, 0, 0, 2, 1, 3'b000, 3'b100, 0};
    vecs[10] = '{1, 0, 0, 0, 1, 0, 3'b001, 3'b100, 0};
    vecs[11] = '{1, 0, 0, 0, 0, 1, 3'b000, 3'b100, 0};
    vecs[12] = '{1, 0, 0, 1, 2, 0, 3'b010, 3'b100, 0};
    vecs[13] = '{1, 0, 0, 1, 1, 0, 3'b010, 3'b100, 0};
    vecs[14] = '{1, 0, 0, 1, 0, 0, 3'b010, 3'b100, 0};
    vecs[15] = '{1, 0, 0, 2, 1, 0, 3'b100, 3'b100, 0};
    vecs[16] = '{1, 0, 0, 2, 0, 0, 3'b100, 3'b100, 0};
    vecs[17] = '{1, 0, 0, 3, 9, 0, 3'b100, 3'b001, 1};
    vecs[18] = '{1, 0, 1, 6, 0, 1, 3'b010, 3'b010, 0};
    vecs[19] = '{1, 0, 1, 6, 0, 0, 3'b000, 3'b000, 0};
    vecs[20] = '{0, 0, 1, 6, 0, 0, 3'b000, 3'b000, 0};
    vecs[21] = '{1, 0, 0, 5, 1, 0, 3'b100, 3'b100, 0};

    bus.tick = 0; bus.ped_req = 0; bus.night = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset", 5, 1, 0, 3'b100, 3'b100, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecs[i].tick, vecs[i].ped, vecs[i].night);
      checkOutput($sformatf("vec%0d", i), vecs[i].ph, vecs[i].cnt, vecs[i].blk,
                  vecs[i].ns, vecs[i].ew, vecs[i].walk);
    end

    // Pedestrian shortening: early request cuts green to SHORT_T, late one does not.
    applyStimulus(1, 0, 0); check_model("seqA");
    applyStimulus(1, 0, 0); check_model("seqA");
    applyStimulus(1, 0, 0); check_model("seqA");
    applyStimulus(0, 1, 0); check_model("pedLatch");
    applyStimulus(1, 0, 0);
    checkOutput("pedShort", 0, 4, 0, 3'b001, 3'b100, 0);
    applyStimulus(1, 0, 0); check_model("seqB");
    applyStimulus(0, 1, 0);
    applyStimulus(1, 0, 0);
    checkOutput("pedLate", 0, 2, 1, 3'b000, 3'b100, 0);
    run_until_phase(3, 20, "toEwG");
    checkOutput("walkEwG", 3, 9, 0, 3'b100, 3'b001, 1);
    run_until_phase(0, 40, "toNsG");
    applyStimulus(1, 0, 0);
    checkOutput("pedCleared", 0, 8, 0, 3'b001, 3'b100, 0);

    // Long idle without tick; a request in the middle is only applied on the next tick.
    for (int i = 0; i < 100; i++) begin
      applyStimulus(0, i == 50, 0);
      check_model("idle");
    end
    checkOutput("idleHold", 0, 8, 0, 3'b001, 3'b100, 0);
    applyStimulus(1, 0, 0);
    checkOutput("idlePed", 0, 4, 0, 3'b001, 3'b100, 0);

    // Asynchronous reset between clock edges, with a request pending.
    run_until_phase(4, 60, "toEwY");
    applyStimulus(0, 1, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checkOutput("asyncRst", 5, 1, 0, 3'b100, 3'b100, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rstRelease", 5, 1, 0, 3'b100, 3'b100, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    checkOutput("rstNsG", 0, 9, 0, 3'b001, 3'b100, 0);
    applyStimulus(1, 0, 0);
    checkOutput("pedDropped", 0, 8, 0, 3'b001, 3'b100, 0);

    night_lvl = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) night_lvl = ~night_lvl;
      applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0, night_lvl);
      check_model("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
